// File: rtl/bcd_enc_pkg.sv
// Shared types and helpers for the active-low line to BCD code encoder.
// Helpers work on a fixed 32-bit mask; callers size-cast to their own widths.
package bcd_enc_pkg;

    localparam int NLINES_DEF = 10;
    localparam int CODE_W_DEF = 4;
    localparam int MASK_W     = 32;
    localparam int IDX_W      = 5;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_e;

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [MASK_W-1:0] mask);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = MASK_W - 1; i >= 0; i--) begin
            if (mask[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    function automatic logic [MASK_W-1:0] onehot(input logic [IDX_W-1:0] code);
        return MASK_W'(1) << code;
    endfunction

endpackage

// File: rtl/prio_enc_lsb.sv
// Combinational priority encoder: lowest set index wins.
module prio_enc_lsb
    import bcd_enc_pkg::*;
#(
    parameter int W  = NLINES_DEF,
    parameter int IW = CODE_W_DEF
) (
    input  logic [W-1:0]  mask_i,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    assign any_o = |mask_i;
    assign idx_o = IW'(lowest_set(MASK_W'(mask_i)));

endmodule

// File: rtl/bcd_line_encoder.sv
// Captures events on one-cold active-low request lines into a pending mask and
// serialises them as binary codes over valid/ready, lowest index first.
module bcd_line_encoder
    import bcd_enc_pkg::*;
#(
    parameter int NLINES       = NLINES_DEF,
    parameter int CODE_W       = CODE_W_DEF,
    parameter bit EDGE_CAPTURE = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NLINES-1:0] lines_n,
    input  logic              cap_en,
    output logic [CODE_W-1:0] code,
    output logic              code_valid,
    input  logic              code_ready,
    output logic [NLINES-1:0] pending,
    output logic              overflow,
    input  logic              clr_ovf
);

    if (NLINES > (1 << CODE_W)) begin : g_bad_code_w
        $error("bcd_line_encoder: NLINES exceeds 2**CODE_W");
    end
    if (NLINES > MASK_W) begin : g_bad_nlines
        $error("bcd_line_encoder: NLINES exceeds helper mask width");
    end

    logic [NLINES-1:0] lines_q, lines_qq;
    logic [NLINES-1:0] act, act_d, ev_raw, ev, clr;
    logic [NLINES-1:0] pending_q, pending_d;
    logic              ovf_q, ovf_d, ovf_set;
    state_e            state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              valid_q, valid_d;
    logic [CODE_W-1:0] enc_idx;
    logic              enc_any;
    logic              hs;

    // Sample stages reset inactive so a line held low across reset release
    // still produces exactly one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lines_q  <= '1;
            lines_qq <= '1;
        end else begin
            lines_q  <= lines_n;
            lines_qq <= lines_q;
        end
    end

    assign act    = ~lines_q;
    assign act_d  = ~lines_qq;
    assign ev_raw = EDGE_CAPTURE ? (act & ~act_d) : act;
    assign ev     = cap_en ? ev_raw : '0;

    assign hs  = valid_q & code_ready;
    assign clr = hs ? NLINES'(onehot(IDX_W'(code_q))) : '0;

    // A fresh event on the line being delivered re-arms it rather than overflowing.
    assign pending_d = (pending_q & ~clr) | ev;
    assign ovf_set   = EDGE_CAPTURE && (|(ev & pending_q & ~clr));
    assign ovf_d     = ovf_set ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);

    prio_enc_lsb #(
        .W  (NLINES),
        .IW (CODE_W)
    ) u_prio (
        .mask_i (pending_q),
        .idx_o  (enc_idx),
        .any_o  (enc_any)
    );

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        valid_d = valid_q;
        unique case (state_q)
            IDLE: begin
                if (enc_any) begin
                    code_d  = enc_idx;
                    valid_d = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (code_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            code_q    <= '0;
            valid_q   <= 1'b0;
            pending_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
        end
    end

    assign code       = code_q;
    assign code_valid = valid_q;
    assign pending    = pending_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_bcd_line_encoder.sv
// Directed bench: edge-capture instance for most steps, level-capture instance
// for the repeating-request step; both share clock and reset.
module tb_bcd_line_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] e_lines, l_lines;
    logic       e_cap, e_rdy, e_clr;
    logic       l_rdy;
    logic [3:0] e_code, l_code;
    logic       e_valid, l_valid, e_ovf, l_ovf;
    logic [9:0] e_pend, l_pend;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bcd_line_encoder #(.NLINES(10), .CODE_W(4), .EDGE_CAPTURE(1'b1)) u_edge (
        .clk(clk), .rst_n(rst_n), .lines_n(e_lines), .cap_en(e_cap),
        .code(e_code), .code_valid(e_valid), .code_ready(e_rdy),
        .pending(e_pend), .overflow(e_ovf), .clr_ovf(e_clr)
    );

    bcd_line_encoder #(.NLINES(10), .CODE_W(4), .EDGE_CAPTURE(1'b0)) u_lvl (
        .clk(clk), .rst_n(rst_n), .lines_n(l_lines), .cap_en(1'b1),
        .code(l_code), .code_valid(l_valid), .code_ready(l_rdy),
        .pending(l_pend), .overflow(l_ovf), .clr_ovf(1'b0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_e(input string tag, input logic v, input logic [3:0] c,
                         input logic [9:0] p, input logic o);
        chk({tag, ".valid"}, 32'(e_valid), 32'(v));
        if (v) chk({tag, ".code"}, 32'(e_code), 32'(c));
        chk({tag, ".pend"}, 32'(e_pend), 32'(p));
        chk({tag, ".ovf"}, 32'(e_ovf), 32'(o));
    endtask

    initial begin
        rst_n   = 1'b0;
        e_lines = 10'h3FF;
        l_lines = 10'h3FF;
        e_cap   = 1'b1;
        e_rdy   = 1'b1;
        e_clr   = 1'b0;
        l_rdy   = 1'b1;
        repeat (3) tick();
        chk("rst.code", 32'(e_code), 32'h0);
        rst_n = 1'b1;

        // Idle after reset
        for (int i = 0; i < 20; i++) chk_e("idle", 1'b0, 4'd0, 10'h000, 1'b0);
        for (int i = 0; i < 20; i++) tick();
        chk_e("idle.end", 1'b0, 4'd0, 10'h000, 1'b0);

        // Single request on line 7, latency
        e_lines = 10'h37F; tick(); e_lines = 10'h3FF;
        chk_e("single.N", 1'b0, 4'd0, 10'h000, 1'b0);
        tick(); chk_e("single.N1", 1'b0, 4'd0, 10'h080, 1'b0);
        tick(); chk_e("single.N2", 1'b1, 4'd7, 10'h080, 1'b0);
        tick(); chk_e("single.N3", 1'b0, 4'd0, 10'h000, 1'b0);

        // Lines 3 and 9 together
        e_lines = 10'h1F7; tick(); e_lines = 10'h3FF;
        tick(); chk_e("dual.N1", 1'b0, 4'd0, 10'h208, 1'b0);
        tick(); chk_e("dual.N2", 1'b1, 4'd3, 10'h208, 1'b0);
        tick(); chk_e("dual.N3", 1'b0, 4'd0, 10'h200, 1'b0);
        tick(); chk_e("dual.N4", 1'b1, 4'd9, 10'h200, 1'b0);
        tick(); chk_e("dual.N5", 1'b0, 4'd0, 10'h000, 1'b0);

        // Backpressure on code 2; lower line 0 must not pre-empt
        e_rdy = 1'b0;
        e_lines = 10'h3FB; tick(); e_lines = 10'h3FF;
        tick(); chk_e("bp.N1", 1'b0, 4'd0, 10'h004, 1'b0);
        tick(); chk_e("bp.N2", 1'b1, 4'd2, 10'h004, 1'b0);
        e_lines = 10'h3FE; tick(); e_lines = 10'h3FF;
        chk_e("bp.N3", 1'b1, 4'd2, 10'h004, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(); chk_e("bp.hold", 1'b1, 4'd2, 10'h005, 1'b0);
        end
        e_rdy = 1'b1;
        tick(); chk_e("bp.hs", 1'b0, 4'd0, 10'h001, 1'b0);
        tick(); chk_e("bp.next", 1'b1, 4'd0, 10'h001, 1'b0);
        tick(); chk_e("bp.drain", 1'b0, 4'd0, 10'h000, 1'b0);

        // Overflow, set wins over clr_ovf, then clear
        e_rdy = 1'b0;
        e_lines = 10'h3DF; tick(); e_lines = 10'h3FF;
        tick(); chk_e("ovf.cap", 1'b0, 4'd0, 10'h020, 1'b0);
        tick(); chk_e("ovf.pres", 1'b1, 4'd5, 10'h020, 1'b0);
        e_lines = 10'h3DF; tick(); e_lines = 10'h3FF;
        tick(); chk_e("ovf.set", 1'b1, 4'd5, 10'h020, 1'b1);
        e_lines = 10'h3DF; tick(); e_lines = 10'h3FF;
        e_clr = 1'b1;
        tick(); chk_e("ovf.setwins", 1'b1, 4'd5, 10'h020, 1'b1);
        tick(); chk_e("ovf.clr", 1'b1, 4'd5, 10'h020, 1'b0);
        e_clr = 1'b0;
        e_rdy = 1'b1;
        tick(); chk_e("ovf.drain", 1'b0, 4'd0, 10'h000, 1'b0);

        // cap_en=0 discards the event on line 4
        e_cap = 1'b0;
        e_lines = 10'h3EF; tick(); e_lines = 10'h3FF;
        tick(); chk_e("mask.N1", 1'b0, 4'd0, 10'h000, 1'b0);
        e_cap = 1'b1;
        tick(); chk_e("mask.N2", 1'b0, 4'd0, 10'h000, 1'b0);
        tick(); chk_e("mask.N3", 1'b0, 4'd0, 10'h000, 1'b0);

        // Level mode: line 1 held low repeats every 2 cycles, no overflow
        l_lines = 10'h3FD; tick();
        tick(); chk("lvl.pend", 32'(l_pend), 32'h002);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("lvl.valid", 32'(l_valid), 32'(i % 2 == 0));
            if (i % 2 == 0) chk("lvl.code", 32'(l_code), 32'h1);
            chk("lvl.pend", 32'(l_pend), 32'h002);
            chk("lvl.ovf", 32'(l_ovf), 32'h0);
        end
        l_lines = 10'h3FF;

        // Asynchronous reset while presenting code 6
        e_rdy = 1'b0;
        e_lines = 10'h3BF; tick(); e_lines = 10'h3FF;
        tick(); tick(); chk_e("arst.pres", 1'b1, 4'd6, 10'h040, 1'b0);
        e_lines = 10'h2FF;
        rst_n = 1'b0;
        #1;
        chk_e("arst.now", 1'b0, 4'd0, 10'h000, 1'b0);
        chk("arst.code", 32'(e_code), 32'h0);
        chk("arst.lvl", 32'(l_valid), 32'h0);
        chk("arst.lpend", 32'(l_pend), 32'h000);
        tick();
        e_rdy = 1'b1;
        rst_n = 1'b1;

        // Line 8 held low across reset release: exactly one delivery
        tick(); chk_e("hold.1", 1'b0, 4'd0, 10'h000, 1'b0);
        tick(); chk_e("hold.2", 1'b0, 4'd0, 10'h100, 1'b0);
        tick(); chk_e("hold.3", 1'b1, 4'd8, 10'h100, 1'b0);
        tick(); chk_e("hold.4", 1'b0, 4'd0, 10'h000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(); chk_e("hold.quiet", 1'b0, 4'd0, 10'h000, 1'b0);
        end
        e_lines = 10'h3FF;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
